onp_eval: RTL and testbench
===========================

# onp_eval

Reverse-Polish (ONP) expression evaluator placed directly downstream of the infix-to-ONP converter. It pops 4-bit ONP tokens from the converter's output FIFO, evaluates them on an internal signed value stack and presents one result per expression, terminated by the `=` token, with a sticky error code. The result is held for a downstream consumer under a valid/ack handshake.

## Interface
- `WIDTH`, 16: value width, two's complement.
- `DEPTH`, 16: value-stack entries (power of 2, ≥2).

- `clk` in 1: clock; all logic rises on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tok_valid` in 1: token available at FIFO head (FO_STB).
- `tok_data` in 4: token at FIFO head (FO_DAT): 0–9 digit, A `+`, B `-`, C `*`, D `=`, E/F illegal.
- `tok_rd` out 1: one-cycle pop strobe to FIFO (FO_ACK).
- `res_valid` out 1: result held, high until acknowledged.
- `res_data` out WIDTH: expression result.
- `res_err` out 3: bit0 underflow, bit1 overflow, bit2 format.
- `res_ack` in 1: consumer takes result.
- `busy` out 1: high when state ≠ IDLE or stack depth ≠ 0.

## Operation
- States: IDLE, EXEC.
- IDLE: if `tok_valid` && !`res_valid`, register `tok_data` into `tok`, set `tok_rd`=1, go to EXEC. Otherwise stay.
- EXEC: `tok_rd` stays high for this cycle only. Act on `tok`, then return to IDLE.
  - Digit: push the zero-extended value. If depth==DEPTH, set err bit1 and leave the stack unchanged.
  - A/B/C: need depth≥2; otherwise set err bit0 and leave the stack unchanged. Pop b (top) and a, then push a+b, a−b or a*b (low WIDTH bits of the product). Net depth −1.
  - E/F: set err bit2.
  - D: if err==0 and depth≠1, set bit2. Load `res_data` with the top entry if the final err==0, else 0. Load `res_err`, set `res_valid`, clear depth and err.
- Once err≠0, later non-`=` tokens are popped and discarded with no stack change.
- Errors are sticky per expression and accumulate bits.
- `res_ack` while `res_valid`: clear `res_valid` next edge. `res_data`/`res_err` hold until the next `=`.
- Stack is a register array addressed by a depth counter of width $clog2(DEPTH+1). Top and top−1 are read combinationally.

## Timing
- Reset values: `tok_rd`=0, `res_valid`=0, `res_data`=0, `res_err`=0, `busy`=0, depth=0, err=0, state IDLE. Stack contents are don't-care.
- Reset mid-expression discards the partial expression and any held result.
- Throughput is one token per 2 cycles. Token sampled at edge N+1 (IDLE→EXEC), `tok_rd` high in cycle N+1, stack update at edge N+2. IDLE re-samples `tok_valid` in cycle N+2 after the FIFO pop.
- Latency from the `=` pop edge to `res_valid` high is 1 cycle.
- Backpressure: no fetch while `res_valid`=1. `tok_rd` is never asserted with `tok_valid`=0.
- `res_ack` and the next `=` cannot coincide, because fetch is blocked while a result is held. `res_ack` while `res_valid`=0 is ignored.
- Boundary: push at depth DEPTH−1 succeeds (depth→DEPTH). The next push sets overflow. The operator path never wraps the depth counter.

## Configuration
- `ONP_EVAL_SAT_EN` defined: `+`, `-`, `*` saturate to +2^(WIDTH−1)−1 / −2^(WIDTH−1) on signed overflow (multiply judged on the full 2·WIDTH product). Saturation does not set err.
- Undefined: modular wrap-around at WIDTH bits.

## Test plan
- Tokens 2,3,A,4,C,D → one `res_valid`, `res_data`=16'd20, `res_err`=0, 6 `tok_rd` pulses, each 2 cycles apart.
- 3,5,B,D → `res_data`=16'hFFFE, `res_err`=0.
- 5,A,D → `res_err`=3'b001, `res_data`=0. Next expression 1,D → 16'd1, err 0 (error cleared).
- 17× digit 1 then D (DEPTH=16) → bit1 set, `res_data`=0. Separately 1,2,D → `res_err`=3'b100. Separately 1,E,D → 3'b100.
- 9,9,C,9,C,9,C,9,C,D → 16'hE6A9 without macro, 16'h7FFF with `ONP_EVAL_SAT_EN`.
- Hold `res_ack`=0 with `tok_valid`=1 after a result → no `tok_rd` for 20 cycles. Pulse `res_ack` → fetch resumes. Assert `rst_n`=0 mid-expression → all outputs 0 asynchronously, and the next expression evaluates correctly.

Source files
------------

// File: rtl/onp_eval.sv
// Reverse-Polish expression evaluator: pops 4-bit ONP tokens, evaluates them on a signed value stack
// and holds one result per '=' under a valid/ack handshake. Define ONP_EVAL_SAT_EN for saturating arithmetic.
module onp_eval #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tok_valid,
   input  logic [3:0]       tok_data,
   output logic             tok_rd,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic [2:0]       res_err,
   input  logic             res_ack,
   output logic             busy
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] TOK_ADD = 4'hA;
   localparam logic [3:0] TOK_SUB = 4'hB;
   localparam logic [3:0] TOK_MUL = 4'hC;
   localparam logic [3:0] TOK_EQ  = 4'hD;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t                  state;
   logic [3:0]              tok;
   logic [DW-1:0]           depth;
   logic [2:0]              err;
   logic [WIDTH-1:0]        stk [DEPTH];

   logic [AW-1:0]           push_idx, top_idx, nxt_idx;
   logic signed [WIDTH-1:0] a, b;
   logic [WIDTH-1:0]        op_res;
   logic [2:0]              fin_err;
   logic                    is_digit, is_op, full, enough;
   logic                    stk_we;
   logic [AW-1:0]           stk_wa;
   logic [WIDTH-1:0]        stk_wd;

`ifdef ONP_EVAL_SAT_EN
   localparam logic signed [2*WIDTH-1:0] SMAX = (2*WIDTH)'({1'b0, {(WIDTH-1){1'b1}}});
   localparam logic signed [2*WIDTH-1:0] SMIN = ~SMAX;
`endif

   // Results are computed at double width so saturation can judge the exact value.
   function automatic logic [WIDTH-1:0] fit(input logic signed [2*WIDTH-1:0] v);
`ifdef ONP_EVAL_SAT_EN
      if (v > SMAX) return SMAX[WIDTH-1:0];
      if (v < SMIN) return SMIN[WIDTH-1:0];
`endif
      return v[WIDTH-1:0];
   endfunction

   assign push_idx = depth[AW-1:0];
   assign top_idx  = push_idx - AW'(1);
   assign nxt_idx  = push_idx - AW'(2);
   assign a        = stk[nxt_idx];
   assign b        = stk[top_idx];
   assign is_digit = (tok <= 4'd9);
   assign is_op    = (tok == TOK_ADD) || (tok == TOK_SUB) || (tok == TOK_MUL);
   assign full     = (depth == DW'(DEPTH));
   assign enough   = (depth >= DW'(2));
   assign fin_err  = err | (((err == 3'b000) && (depth != DW'(1))) ? 3'b100 : 3'b000);
   assign busy     = (state != IDLE) || (depth != '0);

   // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      op_res = '0;
      case (tok)
         TOK_ADD: op_res = fit((2*WIDTH)'(a) + (2*WIDTH)'(b));
         TOK_SUB: op_res = fit((2*WIDTH)'(a) - (2*WIDTH)'(b));
         default: op_res = fit((2*WIDTH)'(a) * (2*WIDTH)'(b));
      endcase
   end

   // Once an error is latched the stack is frozen until the terminating '='.
   always_comb begin
      stk_we = 1'b0;
      stk_wa = push_idx;
      stk_wd = WIDTH'(tok);
      if (state == EXEC && err == 3'b000) begin
         if (is_digit && !full) begin
            stk_we = 1'b1;
         end else if (is_op && enough) begin
            stk_we = 1'b1;
            stk_wa = nxt_idx;
            stk_wd = op_res;
         end
      end
   end

   // NOTE: the stack array has no reset; depth alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (stk_we) stk[stk_wa] <= stk_wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tok       <= '0;
         tok_rd    <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= '0;
         depth     <= '0;
         err       <= '0;
      end else begin
         if (res_ack && res_valid) res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (tok_valid && !res_valid) begin
                  tok    <= tok_data;
                  tok_rd <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               tok_rd <= 1'b0;
               state  <= IDLE;
               if (tok == TOK_EQ) begin
                  res_valid <= 1'b1;
                  res_err   <= fin_err;
                  res_data  <= (fin_err == 3'b000) ? b : '0;
                  depth     <= '0;
                  err       <= '0;
               end else if (err == 3'b000) begin
                  if (is_digit) begin
                     if (full) err[1] <= 1'b1;
                     else      depth  <= depth + DW'(1);
                  end else if (is_op) begin
                     if (!enough) err[0] <= 1'b1;
                     else         depth  <= depth - DW'(1);
                  end else begin
                     err[2] <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onp_eval.sv
// Directed bench for onp_eval: a queue models the upstream FIFO, each task checks one scenario.
module tb_onp_eval;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tok_valid;
   logic [3:0]       tok_data;
   logic             tok_rd;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic [2:0]       res_err;
   logic             res_ack;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] q[$];
   int pulses, gap_bad, empty_rd;

   onp_eval #(.WIDTH(WIDTH), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_data(tok_data), .tok_rd(tok_rd),
      .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ack(res_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic drive_fifo();
      tok_valid = (q.size() > 0);
      tok_data  = (q.size() > 0) ? q[0] : 4'h0;
   endtask

   // Runs the FIFO model at negedges until a result is held or the budget expires.
   task automatic feed(input int budget, output bit done);
      int last;
      last = -1;
      done = 1'b0;
      pulses = 0; gap_bad = 0; empty_rd = 0;
      drive_fifo();
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (tok_rd) begin
            if (q.size() == 0) empty_rd++;
            else void'(q.pop_front());
            pulses++;
            if (last >= 0 && c - last != 2) gap_bad++;
            last = c;
         end
         if (res_valid) done = 1'b1;
         drive_fifo();
      end
   endtask

   task automatic ack();
      @(negedge clk); res_ack = 1'b1;
      @(negedge clk); res_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tok_valid = 1'b0; tok_data = 4'h0; res_ack = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (tok_rd !== 1'b0)    begin n_bad++; $display("FAIL reset_tok_rd got %b want 0", tok_rd); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      n_cmp++; if (res_data !== 16'h0) begin n_bad++; $display("FAIL reset_res_data got %h want 0000", res_data); end
      n_cmp++; if (res_err !== 3'b000) begin n_bad++; $display("FAIL reset_res_err got %b want 000", res_err); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit done;
      q = '{4'h2, 4'h3, 4'hA, 4'h4, 4'hC, 4'hD};
      feed(100, done);
      n_cmp++; if (done !== 1'b1)       begin n_bad++; $display("FAIL basic_done got %b want 1", done); end
      n_cmp++; if (res_data !== 16'd20) begin n_bad++; $display("FAIL basic_data got %h want 0014", res_data); end
      n_cmp++; if (res_err !== 3'b000)  begin n_bad++; $display("FAIL basic_err got %b want 000", res_err); end
      n_cmp++; if (pulses != 6)         begin n_bad++; $display("FAIL basic_pulses got %0d want 6", pulses); end
      n_cmp++; if (gap_bad != 0)        begin n_bad++; $display("FAIL basic_spacing got %0d bad gaps want 0", gap_bad); end
      n_cmp++; if (empty_rd != 0)       begin n_bad++; $display("FAIL basic_rd_empty got %0d want 0", empty_rd); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL basic_busy got %b want 0", busy); end
      ack();
      n_cmp++; if (res_valid !== 1'b0)  begin n_bad++; $display("FAIL basic_ack got %b want 0", res_valid); end
      n_cmp++; if (res_data !== 16'd20) begin n_bad++; $display("FAIL basic_hold got %h want 0014", res_data); end
   endtask

   task automatic test_sub();
      bit done;
      q = '{4'h3, 4'h5, 4'hB, 4'hD};
      feed(100, done);
      n_cmp++; if (done !== 1'b1)         begin n_bad++; $display("FAIL sub_done got %b want 1", done); end
      n_cmp++; if (res_data !== 16'hFFFE) begin n_bad++; $display("FAIL sub_data got %h want fffe", res_data); end
      n_cmp++; if (res_err !== 3'b000)    begin n_bad++; $display("FAIL sub_err got %b want 000", res_err); end
      ack();
   endtask

   task automatic test_underflow();
      bit done;
      q = '{4'h5, 4'hA, 4'hD};
      feed(100, done);
      n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL under_done got %b want 1", done); end
      n_cmp++; if (res_err !== 3'b001) begin n_bad++; $display("FAIL under_err got %b want 001", res_err); end
      n_cmp++; if (res_data !== 16'h0) begin n_bad++; $display("FAIL under_data got %h want 0000", res_data); end
      ack();
      q = '{4'h1, 4'hD};
      feed(100, done);
      n_cmp++; if (res_data !== 16'd1) begin n_bad++; $display("FAIL after_err_data got %h want 0001", res_data); end
      n_cmp++; if (res_err !== 3'b000) begin n_bad++; $display("FAIL after_err_err got %b want 000", res_err); end
      ack();
   endtask

   task automatic test_overflow_format();
      bit done;
      q.delete();
      repeat (17) q.push_back(4'h1);
      q.push_back(4'hD);
      feed(200, done);
      n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL over_done got %b want 1", done); end
      n_cmp++; if (res_err !== 3'b010) begin n_bad++; $display("FAIL over_err got %b want 010", res_err); end
      n_cmp++; if (res_data !== 16'h0) begin n_bad++; $display("FAIL over_data got %h want 0000", res_data); end
      ack();
      q = '{4'h1, 4'h2, 4'hD};
      feed(100, done);
      n_cmp++; if (res_err !== 3'b100) begin n_bad++; $display("FAIL fmt_depth_err got %b want 100", res_err); end
      ack();
      q = '{4'h1, 4'hE, 4'hD};
      feed(100, done);
      n_cmp++; if (res_err !== 3'b100) begin n_bad++; $display("FAIL fmt_illegal_err got %b want 100", res_err); end
      n_cmp++; if (res_data !== 16'h0) begin n_bad++; $display("FAIL fmt_illegal_data got %h want 0000", res_data); end
      ack();
   endtask

   task automatic test_mul_chain();
      bit done;
      logic [WIDTH-1:0] exp;
`ifdef ONP_EVAL_SAT_EN
      exp = 16'h7FFF;
`else
      exp = 16'hE6A9;
`endif
      q = '{4'h9, 4'h9, 4'hC, 4'h9, 4'hC, 4'h9, 4'hC, 4'h9, 4'hC, 4'hD};
      feed(100, done);
      n_cmp++; if (res_data !== exp)   begin n_bad++; $display("FAIL mul_data got %h want %h", res_data, exp); end
      n_cmp++; if (res_err !== 3'b000) begin n_bad++; $display("FAIL mul_err got %b want 000", res_err); end
   endtask

   // Entered with the previous result still unacknowledged.
   task automatic test_backpressure();
      bit done;
      int rd_seen;
      rd_seen = 0;
      q = '{4'h1, 4'hD};
      drive_fifo();
      repeat (20) begin
         @(negedge clk);
         if (tok_rd) rd_seen++;
      end
      n_cmp++; if (rd_seen != 0)       begin n_bad++; $display("FAIL bp_blocked got %0d pops want 0", rd_seen); end
      n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_held got %b want 1", res_valid); end
      ack();
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_ack got %b want 0", res_valid); end
      feed(100, done);
      n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL bp_resume got %b want 1", done); end
      n_cmp++; if (res_data !== 16'd1) begin n_bad++; $display("FAIL bp_data got %h want 0001", res_data); end
      ack();
   endtask

   task automatic test_reset_mid();
      bit done;
      q = '{4'h7, 4'h8, 4'hA, 4'hD};
      feed(5, done);
      n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (tok_rd !== 1'b0)    begin n_bad++; $display("FAIL mid_tok_rd got %b want 0", tok_rd); end
      n_cmp++; if (res_data !== 16'h0) begin n_bad++; $display("FAIL mid_data got %h want 0000", res_data); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL mid_busy_clr got %b want 0", busy); end
      q.delete();
      drive_fifo();
      @(negedge clk); rst_n = 1'b1;
      q = '{4'h2, 4'h2, 4'hA, 4'hD};
      feed(100, done);
      n_cmp++; if (res_data !== 16'd4) begin n_bad++; $display("FAIL mid_next_data got %h want 0004", res_data); end
      n_cmp++; if (res_err !== 3'b000) begin n_bad++; $display("FAIL mid_next_err got %b want 000", res_err); end
      ack();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sub();
      test_underflow();
      test_overflow_format();
      test_mul_chain();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
